// File: rtl/calc1_pkg.sv
// Shared widths, command/response codes and driver FSM states for the calc1 port adapters.
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP1,
        ST_SEND_OP2,
        ST_WAIT_RESP,
        ST_DONE
    } drv_state_t;

    function automatic logic is_resp(input logic [RESP_W-1:0] resp);
        return resp != RESP_NONE;
    endfunction

endpackage

// File: rtl/calc1_resp_timer.sv
// Saturating response-wait counter; expired pulses on the cycle whose edge completes TIMEOUT_CYCLES.
module calc1_resp_timer #(
    parameter int TIMEOUT_CYCLES = 10,
    parameter int CNT_W          = 8
) (
    input  logic c_clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt < CNT_W'(TIMEOUT_CYCLES))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The edge that would bring cnt to TIMEOUT_CYCLES is the expiring one.
    always_comb begin
        expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/calc1_port_driver.sv
// Adapter serialising one (cmd, op1, op2) request onto a calc1 port and returning its response or a timeout.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10,
    parameter int CNT_W          = 8
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [0:CMD_W-1]  req_cmd,
    input  logic [0:DATA_W-1] req_op1,
    input  logic [0:DATA_W-1] req_op2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [0:RESP_W-1] rsp_code,
    output logic [0:DATA_W-1] rsp_data,
    output logic              rsp_timeout,
    output logic [0:CMD_W-1]  calc_cmd_out,
    output logic [0:DATA_W-1] calc_data_out,
    input  logic [0:RESP_W-1] calc_resp_in,
    input  logic [0:DATA_W-1] calc_data_in,
    output logic              busy
);

    drv_state_t        state_q, state_d;
    logic [0:DATA_W-1] op2_q, op2_d;
    logic [0:CMD_W-1]  cmd_d;
    logic [0:DATA_W-1] data_d;
    logic              rsp_valid_d;
    logic [0:RESP_W-1] rsp_code_d;
    logic [0:DATA_W-1] rsp_data_d;
    logic              rsp_timeout_d;
    logic              req_ready_d;
    logic              busy_d;

    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    calc1_resp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .c_clk  (c_clk),
        .reset  (reset),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op2_q         <= '0;
            calc_cmd_out  <= '0;
            calc_data_out <= '0;
            rsp_valid     <= 1'b0;
            rsp_code      <= '0;
            rsp_data      <= '0;
            rsp_timeout   <= 1'b0;
            req_ready     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            op2_q         <= op2_d;
            calc_cmd_out  <= cmd_d;
            calc_data_out <= data_d;
            rsp_valid     <= rsp_valid_d;
            rsp_code      <= rsp_code_d;
            rsp_data      <= rsp_data_d;
            rsp_timeout   <= rsp_timeout_d;
            req_ready     <= req_ready_d;
            busy          <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op2_d         = op2_q;
        cmd_d         = '0;
        data_d        = calc_data_out;
        rsp_valid_d   = rsp_valid;
        rsp_code_d    = rsp_code;
        rsp_data_d    = rsp_data;
        rsp_timeout_d = rsp_timeout;
        timer_clr     = (state_q == ST_SEND_OP2);
        timer_en      = (state_q == ST_WAIT_RESP);

        unique case (state_q)
            ST_IDLE: begin
                // cmd and op1 are latched straight into the drive registers.
                if (req_valid && req_ready) begin
                    op2_d = req_op2;
                    if (req_cmd != CMD_NOP) begin
                        state_d = ST_SEND_OP1;
                        cmd_d   = req_cmd;
                        data_d  = req_op1;
                    end else begin
                        state_d       = ST_DONE;
                        rsp_valid_d   = 1'b1;
                        rsp_code_d    = RESP_ERR;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end
            ST_SEND_OP1: begin
                state_d = ST_SEND_OP2;
                data_d  = op2_q;
            end
            ST_SEND_OP2: begin
                state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                // A response on the expiring edge takes priority over the timeout.
                if (is_resp(calc_resp_in)) begin
                    state_d       = ST_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_code_d    = calc_resp_in;
                    rsp_data_d    = calc_data_in;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    state_d       = ST_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_code_d    = RESP_NONE;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_valid && rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Randomised transaction-level bench for calc1_port_driver against a latency/result reference model.
module tb_calc1_port_driver;

    localparam int T = 10;

    logic        c_clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [0:3]  req_cmd;
    logic [0:31] req_op1;
    logic [0:31] req_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic        rsp_timeout;
    logic [0:3]  calc_cmd_out;
    logic [0:31] calc_data_out;
    logic [0:1]  calc_resp_in;
    logic [0:31] calc_data_in;
    logic        busy;

    int n_checks;
    int n_errors;

    calc1_port_driver #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (8)
    ) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_code     (rsp_code),
        .rsp_data     (rsp_data),
        .rsp_timeout  (rsp_timeout),
        .calc_cmd_out (calc_cmd_out),
        .calc_data_out(calc_data_out),
        .calc_resp_in (calc_resp_in),
        .calc_data_in (calc_data_in),
        .busy         (busy)
    );

    initial c_clk = 1'b0;
    always #100 c_clk = ~c_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // k = WAIT_RESP cycle (0-based) in which calc1 answers; k<0 or k>=T means it never does.
    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                           input int k, input logic [1:0] rcode, input logic [31:0] rdata,
                           input int hold, input bit try_second);
        bit          legal;
        bit          timed_out;
        int          lat;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;

        legal     = (cmd != 4'd0);
        timed_out = legal && (k < 0 || k >= T);
        lat       = !legal ? 0 : (timed_out ? 2 + T : 3 + k);
        exp_code  = !legal ? 2'd2 : (timed_out ? 2'd0 : rcode);
        exp_data  = (!legal || timed_out) ? 32'd0 : rdata;

        rsp_ready    = 1'b0;
        calc_resp_in = '0;
        check_val("req_ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_op1   = op1;
        req_op2   = op2;

        for (int e = 0; e <= lat; e++) begin
            if (legal && !timed_out && e == 3 + k) begin
                calc_resp_in = rcode;
                calc_data_in = rdata;
            end else begin
                calc_resp_in = '0;
                calc_data_in = $urandom;
            end
            tick();
            if (e == 0) begin
                req_valid = 1'b0;
                req_cmd   = 4'($urandom);
                req_op1   = $urandom;
                req_op2   = $urandom;
            end
            if (e < lat) begin
                check_val("rsp_valid_early", rsp_valid, 0);
                check_val("req_ready_busy", req_ready, 0);
                check_val("busy_active", busy, 1);
                check_val("calc_cmd_drive", calc_cmd_out, (e == 0) ? 32'(cmd) : 32'd0);
                check_val("calc_data_drive", calc_data_out, (e == 0) ? op1 : op2);
            end else begin
                check_val("rsp_valid_at_latency", rsp_valid, 1);
                check_val("rsp_code", rsp_code, 32'(exp_code));
                check_val("rsp_data", rsp_data, exp_data);
                check_val("rsp_timeout", rsp_timeout, 32'(timed_out));
                check_val("calc_cmd_done", calc_cmd_out, 0);
                check_val("req_ready_done", req_ready, 0);
                if (legal) check_val("calc_data_hold", calc_data_out, op2);
            end
        end
        calc_resp_in = '0;

        for (int h = 0; h < hold; h++) begin
            if (try_second) begin
                req_valid = 1'b1;
                req_cmd   = 4'd1;
                req_op1   = $urandom;
                req_op2   = $urandom;
            end
            tick();
            check_val("bp_rsp_valid", rsp_valid, 1);
            check_val("bp_rsp_code", rsp_code, 32'(exp_code));
            check_val("bp_rsp_data", rsp_data, exp_data);
            check_val("bp_rsp_timeout", rsp_timeout, 32'(timed_out));
            check_val("bp_req_ready", req_ready, 0);
            check_val("bp_calc_cmd", calc_cmd_out, 0);
        end

        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check_val("rsp_valid_dropped", rsp_valid, 0);
        check_val("req_ready_idle", req_ready, 1);
        check_val("busy_idle", busy, 0);
        check_val("calc_cmd_idle", calc_cmd_out, 0);
    endtask

    initial begin
        int          k;
        int          sel;
        logic [3:0]  cmd;

        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_cmd      = '0;
        req_op1      = '0;
        req_op2      = '0;
        rsp_ready    = 1'b0;
        calc_resp_in = '0;
        calc_data_in = '0;

        #1;
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_calc_cmd", calc_cmd_out, 0);
        check_val("rst_calc_data", calc_data_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_rsp_code", rsp_code, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_timeout", rsp_timeout, 0);
        tick();
        tick();
        #50 reset = 1'b0;
        tick();
        check_val("post_rst_req_ready", req_ready, 1);

        run_txn(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2, 2'd1, 32'h2000_0000, 0, 1'b0);
        run_txn(4'd1, 32'h8000_0000, 32'h8000_0000, 0, 2'd2, 32'h0000_0000, 0, 1'b0);
        run_txn(4'd1, 32'h0000_8000, 32'h0000_0000, -1, 2'd1, 32'h0, 0, 1'b0);
        run_txn(4'd2, 32'h1234_5678, 32'h9ABC_DEF0, T - 1, 2'd3, 32'hCAFE_F00D, 0, 1'b0);
        run_txn(4'd0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1, 2'd1, 32'h1, 0, 1'b0);
        run_txn(4'd5, 32'h0000_0003, 32'h0000_0004, 1, 2'd1, 32'h0000_0030, 5, 1'b1);

        // Reset while the second operand is being driven.
        req_valid = 1'b1;
        req_cmd   = 4'd6;
        req_op1   = 32'h0F0F_0F0F;
        req_op2   = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        tick();
        check_val("pre_rst_calc_data", calc_data_out, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        check_val("mid_rst_calc_cmd", calc_cmd_out, 0);
        check_val("mid_rst_calc_data", calc_data_out, 0);
        check_val("mid_rst_rsp_valid", rsp_valid, 0);
        check_val("mid_rst_req_ready", req_ready, 0);
        tick();
        #50 reset = 1'b0;
        tick();
        check_val("rel_rst_req_ready", req_ready, 1);
        check_val("rel_rst_busy", busy, 0);
        check_val("rel_rst_rsp_valid", rsp_valid, 0);

        // Stale response while idle.
        calc_resp_in = 2'd1;
        calc_data_in = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("late_rsp_valid", rsp_valid, 0);
            check_val("late_busy", busy, 0);
            check_val("late_req_ready", req_ready, 1);
        end
        calc_resp_in = '0;
        run_txn(4'd1, 32'h0000_0003, 32'h0000_0007, 1, 2'd1, 32'h0000_000A, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: cmd = 4'd0;
                1: cmd = 4'd1;
                2: cmd = 4'd2;
                3: cmd = 4'd5;
                4: cmd = 4'd6;
                default: cmd = 4'($urandom_range(1, 15));
            endcase
            k = int'($urandom_range(0, 13)) - 1;
            run_txn(cmd, $urandom, $urandom, k, 2'($urandom_range(1, 3)), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
